emsg_sched: RTL and testbench

EMSG_SCHED -- requirements
Module: emsg_sched

---
 rtl/emsg_sched_pkg.sv | 22 ++
 rtl/emsg_pipe_track.sv | 39 +++
 rtl/emsg_sched.sv | 139 +++++++++++++
 tb/tb_emsg_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/emsg_sched_pkg.sv
// rtl/emsg_sched_pkg.sv - shared widths, defaults and FSM encoding for the row scheduler and emsggen cover
package emsg_sched_pkg;

  localparam int W_DEF   = 6;
  localparam int WC_DEF  = 18;
  localparam int RW_DEF  = 8;
  localparam int IW_DEF  = 5;
  localparam int LAT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Compressed row message: min1 and min2 magnitudes, 5-bit min index, one sign per input
  function automatic int ew_of(input int w, input int wc);
    return 2 * (w - 1) + wc + 5;
  endfunction

endpackage

// File: rtl/emsg_pipe_track.sv
// rtl/emsg_pipe_track.sv - LAT-deep valid/address shift register tracking rows in flight
module emsg_pipe_track
  import emsg_sched_pkg::*;
#(
  parameter int RW  = RW_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] in_addr,
  output logic          tail_valid,
  output logic [RW-1:0] tail_addr,
  output logic          empty
);

  logic [LAT-1:0] vld;
  logic [RW-1:0]  addr [LAT];

  // Shift issued row addresses toward the tail; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) addr[i] <= '0;
    end else begin
      vld[0]  <= in_valid;
      addr[0] <= in_valid ? in_addr : '0;
      for (int i = 1; i < LAT; i++) begin
        vld[i]  <= vld[i-1];
        addr[i] <= addr[i-1];
      end
    end
  end

  assign tail_valid = vld[LAT-1];
  assign tail_addr  = addr[LAT-1];
  assign empty      = ~|vld;

endmodule

// File: rtl/emsg_sched.sv
// rtl/emsg_sched.sv - row/iteration scheduler for compressed check-node messages; optional EMSG_EARLY_TERM_EN
module emsg_sched
  import emsg_sched_pkg::*;
#(
  parameter int  W   = W_DEF,
  parameter int  WC  = WC_DEF,
  parameter int  RW  = RW_DEF,
  parameter int  IW  = IW_DEF,
  parameter int  LAT = LAT_DEF,
  localparam int EW  = ew_of(W, WC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic [IW-1:0] max_iter,
  input  logic          stall,
  input  logic          parity_ok,
  input  logic [EW-1:0] ecomp_in,
  output logic          busy,
  output logic          rd_en,
  output logic [RW-1:0] rd_addr,
  output logic          wr_en,
  output logic [RW-1:0] wr_addr,
  output logic [EW-1:0] wr_data,
  output logic [IW-1:0] iter_cnt,
  output logic          done,
  output logic          early
);

  state_t        state, state_nxt;
  logic [RW-1:0] row, rows_q;
  logic [IW-1:0] iter, iters_q, iter_inc;
  logic          early_q;
  logic          issue, iter_end, stop_early, early_hit, last_row;
  logic          pipe_empty, tail_valid;
  logic [RW-1:0] tail_addr;

`ifdef EMSG_EARLY_TERM_EN
  assign early_hit = parity_ok;
`else
  logic unused_parity;
  assign unused_parity = parity_ok;
  assign early_hit     = 1'b0;
`endif

  assign last_row = (row == rows_q - RW'(1));
  assign iter_inc = iter + IW'(1);

  // Next-state decode: issue rows in RUN, wait for the pipe to empty in DRAIN
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    iter_end   = 1'b0;
    stop_early = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (num_rows == '0 || max_iter == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (last_row) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          iter_end = 1'b1;
          if (early_hit) begin
            stop_early = 1'b1;
            state_nxt  = ST_DONE;
          end else if (iter_inc == iters_q) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Job parameters, row and iteration counters; job values only load from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q  <= '0;
      iters_q <= '0;
      row     <= '0;
      iter    <= '0;
      early_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        rows_q  <= num_rows;
        iters_q <= max_iter;
        row     <= '0;
        iter    <= '0;
        early_q <= 1'b0;
      end
      if (issue) row <= last_row ? '0 : row + RW'(1);
      if (iter_end) begin
        iter    <= iter_inc;
        early_q <= stop_early;
      end
    end
  end

  emsg_pipe_track #(
    .RW  (RW),
    .LAT (LAT)
  ) u_track (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (issue),
    .in_addr    (row),
    .tail_valid (tail_valid),
    .tail_addr  (tail_addr),
    .empty      (pipe_empty)
  );

  assign rd_en    = issue;
  assign rd_addr  = issue ? row : '0;
  assign wr_en    = tail_valid;
  assign wr_addr  = tail_valid ? tail_addr : '0;
  assign wr_data  = tail_valid ? ecomp_in : '0;
  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);
  assign early    = done && early_q;
  assign iter_cnt = iter;

endmodule

// File: tb/tb_emsg_sched.sv
// tb/tb_emsg_sched.sv - directed self-checking bench for emsg_sched
module tb_emsg_sched;

  localparam int RW = 8;
  localparam int IW = 5;
  localparam int EW = 2 * (6 - 1) + 18 + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic [IW-1:0] max_iter = '0;
  logic          stall = 1'b0;
  logic          parity_ok = 1'b0;
  logic [EW-1:0] ecomp_in;
  logic          busy, rd_en, wr_en, done, early;
  logic [RW-1:0] rd_addr, wr_addr;
  logic [EW-1:0] wr_data;
  logic [IW-1:0] iter_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int zero_viol = 0;

  int            rd_cyc[$];
  logic [RW-1:0] rd_adr[$];
  int            wr_cyc[$];
  logic [RW-1:0] wr_adr[$];
  logic [EW-1:0] wr_dat[$];
  int            dn_cyc[$];
  logic          dn_early[$];
  logic [IW-1:0] dn_iter[$];

  emsg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_rows  (num_rows),
    .max_iter  (max_iter),
    .stall     (stall),
    .parity_ok (parity_ok),
    .ecomp_in  (ecomp_in),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iter_cnt  (iter_cnt),
    .done      (done),
    .early     (early)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] exp_ecomp(input int c);
    logic [EW-1:0] v;
    v = EW'(c * 1021 + 77);
    return {v[EW-1:16] ^ v[15:0], v[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  assign ecomp_in = exp_ecomp(cyc);

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin rd_cyc.push_back(cyc); rd_adr.push_back(rd_addr); end
    if (wr_en === 1'b1) begin wr_cyc.push_back(cyc); wr_adr.push_back(wr_addr); wr_dat.push_back(wr_data); end
    if (done === 1'b1) begin dn_cyc.push_back(cyc); dn_early.push_back(early); dn_iter.push_back(iter_cnt); end
    if (rd_en === 1'b0 && rd_addr !== '0) zero_viol++;
    if (wr_en === 1'b0 && (wr_addr !== '0 || wr_data !== '0)) zero_viol++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_adr.delete();
    wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
    dn_cyc.delete(); dn_early.delete(); dn_iter.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || early !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", done, early); end
    checks++; if (rd_en !== 1'b0 || rd_addr !== '0) begin failures++; $display("FAIL reset_rd got=%b/%0d exp=0/0", rd_en, rd_addr); end
    checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin failures++; $display("FAIL reset_wr got=%b/%0d/%0h exp=0/0/0", wr_en, wr_addr, wr_data); end
    checks++; if (iter_cnt !== '0) begin failures++; $display("FAIL reset_iter got=%0d exp=0", iter_cnt); end
    tick(1);
  endtask

  task automatic test_basic();
    int s, er;
    clear_logs();
    num_rows = 4; max_iter = 2; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(24);
    checks++; if (rd_cyc.size() != 8) begin failures++; $display("FAIL basic_rd_count got=%0d exp=8", rd_cyc.size()); end
    for (int i = 0; i < 8 && i < rd_cyc.size(); i++) begin
      er = (i < 4) ? s + 1 + i : s + 5 + i;
      checks++; if (rd_adr[i] !== RW'(i % 4) || rd_cyc[i] != er) begin failures++; $display("FAIL basic_rd[%0d] got=%0d@%0d exp=%0d@%0d", i, rd_adr[i], rd_cyc[i], i % 4, er); end
    end
    checks++; if (wr_cyc.size() != 8) begin failures++; $display("FAIL basic_wr_count got=%0d exp=8", wr_cyc.size()); end
    for (int i = 0; i < 8 && i < wr_cyc.size(); i++) begin
      er = ((i < 4) ? s + 1 + i : s + 5 + i) + 3;
      checks++; if (wr_adr[i] !== RW'(i % 4) || wr_cyc[i] != er || wr_dat[i] !== exp_ecomp(er)) begin failures++; $display("FAIL basic_wr[%0d] got=%0d@%0d/%0h exp=%0d@%0d/%0h", i, wr_adr[i], wr_cyc[i], wr_dat[i], i % 4, er, exp_ecomp(er)); end
    end
    checks++; if (dn_cyc.size() != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dn_cyc.size()); end
    else begin
      checks++; if (dn_cyc[0] != s + 17 || dn_iter[0] !== IW'(2) || dn_early[0] !== 1'b0) begin failures++; $display("FAIL basic_done got=@%0d it=%0d e=%b exp=@%0d it=2 e=0", dn_cyc[0], dn_iter[0], dn_early[0], s + 17); end
    end
  endtask

  task automatic test_stall();
    int s;
    int exp_rd[4] = '{1, 2, 5, 6};
    clear_logs();
    num_rows = 4; max_iter = 1; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(2); stall = 1'b1;
    tick(2); stall = 1'b0;
    tick(15);
    checks++; if (rd_cyc.size() != 4 || wr_cyc.size() != 4) begin failures++; $display("FAIL stall_count got=rd%0d/wr%0d exp=rd4/wr4", rd_cyc.size(), wr_cyc.size()); end
    for (int i = 0; i < 4 && i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
      checks++; if (rd_adr[i] !== RW'(i) || rd_cyc[i] != s + exp_rd[i]) begin failures++; $display("FAIL stall_rd[%0d] got=%0d@%0d exp=%0d@%0d", i, rd_adr[i], rd_cyc[i], i, s + exp_rd[i]); end
      checks++; if (wr_adr[i] !== RW'(i) || wr_cyc[i] != s + exp_rd[i] + 3) begin failures++; $display("FAIL stall_wr[%0d] got=%0d@%0d exp=%0d@%0d", i, wr_adr[i], wr_cyc[i], i, s + exp_rd[i] + 3); end
    end
    checks++; if (dn_cyc.size() != 1 || dn_cyc[0] != s + 11) begin failures++; $display("FAIL stall_done got=n%0d exp=one@%0d", dn_cyc.size(), s + 11); end
  endtask

  task automatic test_zero();
    int s;
    clear_logs();
    num_rows = 0; max_iter = 3; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(5);
    checks++; if (dn_cyc.size() != 1 || dn_cyc[0] != s + 1) begin failures++; $display("FAIL zero_rows_done got=n%0d exp=one@%0d", dn_cyc.size(), s + 1); end
    checks++; if (rd_cyc.size() != 0 || wr_cyc.size() != 0) begin failures++; $display("FAIL zero_rows_io got=rd%0d/wr%0d exp=0/0", rd_cyc.size(), wr_cyc.size()); end
    clear_logs();
    num_rows = 4; max_iter = 0; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(5);
    checks++; if (dn_cyc.size() != 1 || dn_cyc[0] != s + 1 || dn_iter[0] !== '0) begin failures++; $display("FAIL zero_iter_done got=n%0d exp=one@%0d it=0", dn_cyc.size(), s + 1); end
    checks++; if (rd_cyc.size() != 0 || wr_cyc.size() != 0) begin failures++; $display("FAIL zero_iter_io got=rd%0d/wr%0d exp=0/0", rd_cyc.size(), wr_cyc.size()); end
  endtask

  task automatic test_reset_midrun();
    int s;
    clear_logs();
    num_rows = 8; max_iter = 1; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL midrst_idle got=b%b r%b w%b exp=000", busy, rd_en, wr_en); end
    tick(8);
    checks++; if (rd_cyc.size() != 2 || wr_cyc.size() != 0 || dn_cyc.size() != 0) begin failures++; $display("FAIL midrst_flush got=rd%0d/wr%0d/dn%0d exp=2/0/0", rd_cyc.size(), wr_cyc.size(), dn_cyc.size()); end
    clear_logs();
    num_rows = 2; max_iter = 1; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(10);
    checks++; if (wr_cyc.size() != 2 || (wr_cyc.size() == 2 && (wr_adr[0] !== 8'd0 || wr_adr[1] !== 8'd1 || wr_cyc[0] != s + 4))) begin failures++; $display("FAIL midrst_rerun_wr got=n%0d exp=2 rows 0,1 from @%0d", wr_cyc.size(), s + 4); end
    checks++; if (dn_cyc.size() != 1 || dn_cyc[0] != s + 7) begin failures++; $display("FAIL midrst_rerun_done got=n%0d exp=one@%0d", dn_cyc.size(), s + 7); end
  endtask

  task automatic test_restart_busy();
    int s, er;
    clear_logs();
    num_rows = 3; max_iter = 2; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(1); start = 1'b1; num_rows = 7; max_iter = 9;
    tick(1); start = 1'b0;
    tick(2); start = 1'b1;
    tick(1); start = 1'b0;
    tick(20);
    checks++; if (rd_cyc.size() != 6) begin failures++; $display("FAIL restart_rd_count got=%0d exp=6", rd_cyc.size()); end
    for (int i = 0; i < 6 && i < rd_cyc.size(); i++) begin
      er = (i < 3) ? s + 1 + i : s + 5 + i;
      checks++; if (rd_adr[i] !== RW'(i % 3) || rd_cyc[i] != er) begin failures++; $display("FAIL restart_rd[%0d] got=%0d@%0d exp=%0d@%0d", i, rd_adr[i], rd_cyc[i], i % 3, er); end
    end
    checks++; if (dn_cyc.size() != 1 || dn_cyc[0] != s + 15 || dn_iter[0] !== IW'(2)) begin failures++; $display("FAIL restart_done got=n%0d exp=one@%0d it=2", dn_cyc.size(), s + 15); end
  endtask

  task automatic test_early();
    int s, edone;
    logic [IW-1:0] eit;
    logic ee;
`ifdef EMSG_EARLY_TERM_EN
    edone = 13; eit = 2; ee = 1'b1;
`else
    edone = 31; eit = 5; ee = 1'b0;
`endif
    clear_logs();
    num_rows = 2; max_iter = 5; start = 1'b1; s = cyc;
    tick(1); start = 1'b0;
    tick(6); parity_ok = 1'b1;
    tick(30); parity_ok = 1'b0;
    checks++; if (dn_cyc.size() != 1) begin failures++; $display("FAIL early_done_count got=%0d exp=1", dn_cyc.size()); end
    else begin
      checks++; if (dn_cyc[0] != s + edone || dn_iter[0] !== eit || dn_early[0] !== ee) begin failures++; $display("FAIL early_done got=@%0d it=%0d e=%b exp=@%0d it=%0d e=%b", dn_cyc[0], dn_iter[0], dn_early[0], s + edone, eit, ee); end
    end
    checks++; if (wr_cyc.size() != 2 * int'(eit)) begin failures++; $display("FAIL early_wr_count got=%0d exp=%0d", wr_cyc.size(), 2 * int'(eit)); end
  endtask

  task automatic test_strobe_zero();
    checks++; if (zero_viol != 0) begin failures++; $display("FAIL strobe_zero got=%0d exp=0", zero_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_reset_midrun();
    test_restart_busy();
    test_early();
    test_strobe_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
